// File: rtl/sha256_stream_core.sv
// SHA-256/224 compression core fed one 32-bit message word per handshake.
// ROUNDS_PER_CYCLE chained rounds run per HASH cycle; first/last flags frame messages.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode_i,
  input  logic [31:0]  word_i,
  input  logic         word_valid_i,
  output logic         word_ready_o,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic [255:0] digest_o,
  output logic         digest_valid_o
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_RCNT = 6'(64 - R);
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_LOAD, S_HASH, S_UPDATE} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Window plus R freshly extended schedule words; entry 0 is the oldest.
  function automatic logic [15+R:0][31:0] expand(input logic [15:0][31:0] win);
    logic [15+R:0][31:0] e;
    for (int j = 0; j < 16; j++) e[j] = win[j];
    for (int i = 0; i < R; i++)
      e[16+i] = small_sigma1(e[14+i]) + e[9+i] + small_sigma0(e[1+i]) + e[i];
    return e;
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] run_rounds(input logic [255:0] v, input logic [15+R:0][31:0] e,
                                              input logic [5:0] rc);
    logic [255:0] x;
    x = v;
    for (int i = 0; i < R; i++) x = sha_round(x, K[rc + 6'(i)], e[i]);
    return x;
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return s;
  endfunction

  state_t              state_q;
  logic [3:0]          wcnt_q;
  logic [5:0]          rcnt_q;
  logic [255:0]        h_q;
  logic                mode_q;
  logic                last_q;
  logic [255:0]        digest_q;
  logic                digest_valid_q;
  logic [15:0][31:0]   w_q;
  logic [255:0]        v_q;
  logic [15+R:0][31:0] ext;
  logic [255:0]        v_next;
  logic [255:0]        h_new;

  assign ext    = expand(w_q);
  assign v_next = run_rounds(v_q, ext, rcnt_q);
  assign h_new  = add_words(h_q, v_q);

  assign word_ready_o   = (state_q == S_LOAD);
  assign busy_o         = (state_q != S_LOAD);
  assign digest_o       = digest_q;
  assign digest_valid_o = digest_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_LOAD;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      h_q            <= IV256;
      mode_q         <= 1'b0;
      last_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else if (abort_i) begin
      // Abort outranks a word handshake in the same cycle; that word is dropped.
      state_q        <= S_LOAD;
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      h_q            <= IV256;
      mode_q         <= 1'b0;
      last_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (word_valid_i) begin
            wcnt_q <= wcnt_q + 4'd1;
            if (wcnt_q == 4'd0 && first_i) begin
              h_q            <= mode_i ? IV224 : IV256;
              mode_q         <= mode_i;
              digest_valid_q <= 1'b0;
            end
            if (wcnt_q == 4'd15) begin
              last_q  <= last_i;
              rcnt_q  <= '0;
              state_q <= S_HASH;
            end
          end
        end
        S_HASH: begin
          rcnt_q <= rcnt_q + 6'(R);
          if (rcnt_q == LAST_RCNT) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          h_q <= h_new;
          if (last_q) begin
            digest_q       <= mode_q ? {h_new[255:32], 32'h0} : h_new;
            digest_valid_q <= 1'b1;
          end
          wcnt_q  <= '0;
          state_q <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Datapath registers: message window and working variables a..h.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && word_valid_i) begin
      w_q <= {word_i, w_q[15:1]};
      if (wcnt_q == 4'd15) v_q <= h_q;
    end else if (state_q == S_HASH) begin
      w_q <= ext[15+R:R];
      v_q <= v_next;
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: three instances (R = 1, 4, 8) exercised with
// a vector table, a digest scoreboard and hand-written abort/reset/hold sequences.
module tb_sha256_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   mode_i, word_valid_i, first_i, last_i, abort_i;
  logic [2:0]   word_ready_o, busy_o, digest_valid_o;
  logic [31:0]  word_i   [3];
  logic [255:0] digest_o [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RG = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    sha256_stream_core #(.ROUNDS_PER_CYCLE(RG)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mode_i         (mode_i[g]),
      .word_i         (word_i[g]),
      .word_valid_i   (word_valid_i[g]),
      .word_ready_o   (word_ready_o[g]),
      .first_i        (first_i[g]),
      .last_i         (last_i[g]),
      .abort_i        (abort_i[g]),
      .busy_o         (busy_o[g]),
      .digest_o       (digest_o[g]),
      .digest_valid_o (digest_valid_o[g])
    );
  end

  localparam logic [511:0] ABC    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 =
    256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    int            inst;
    logic          mode;
    int            nblk;
    bit            gaps;
    logic [1023:0] msg;
    logic [255:0]  exp;
  } vec_t;

  vec_t         vecs [5];
  logic [255:0] exp_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic int r_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_ready%0d", tag, k), 256'(word_ready_o[k]), 256'(1));
      check($sformatf("%s_busy%0d", tag, k), 256'(busy_o[k]), 256'(0));
      check($sformatf("%s_dvalid%0d", tag, k), 256'(digest_valid_o[k]), 256'(0));
      check($sformatf("%s_digest%0d", tag, k), digest_o[k], 256'(0));
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the last handshake.
  task automatic send_words(input int k, input logic [511:0] blk, input logic first,
                            input logic last, input logic md, input bit gaps, input int nwords);
    int cnt;
    for (int j = 0; j < nwords; j++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        word_valid_i[k] = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      word_i[k]       = blk[511 - 32*j -: 32];
      first_i[k]      = (j == 0)  ? first : 1'($urandom);
      last_i[k]       = (j == 15) ? last  : 1'($urandom);
      mode_i[k]       = (j == 0)  ? md    : 1'($urandom);
      word_valid_i[k] = 1'b1;
      cnt = 0;
      while (!word_ready_o[k] && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_wait inst%0d word%0d: ready still low after %0d cycles", k, j, cnt);
      end
      @(negedge clk);
    end
    word_valid_i[k] = 1'b0;
  endtask

  task automatic finish_block(input int k, input logic last, input string name);
    int cnt;
    bit saw_valid;
    logic [255:0] e;
    cnt = 0;
    saw_valid = 1'b0;
    while (!word_ready_o[k] && cnt < 300) begin
      if (digest_valid_o[k]) saw_valid = 1'b1;
      cnt++;
      @(negedge clk);
    end
    check({name, "_ready_low_cycles"}, 256'(cnt), 256'(64 / r_of(k) + 1));
    check({name, "_dvalid_in_window"}, 256'(saw_valid), 256'(0));
    check({name, "_dvalid_after"}, 256'(digest_valid_o[k]), 256'(last));
    if (last) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_scoreboard: got digest %h, expected nothing queued", name, digest_o[k]);
      end else begin
        e = exp_q.pop_front();
        check({name, "_digest"}, digest_o[k], e);
      end
    end
  endtask

  task automatic run_abc(input int k, input logic md, input logic [255:0] exp, input string name);
    exp_q.push_back(exp);
    send_words(k, ABC, 1'b1, 1'b1, md, 1'b0, 16);
    finish_block(k, 1'b1, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit stable;
    rst_n        = 1'b0;
    mode_i       = '0;
    word_valid_i = '0;
    first_i      = '0;
    last_i       = '0;
    abort_i      = '0;
    for (int k = 0; k < 3; k++) word_i[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{0, 1'b0, 1, 1'b0, {ABC, 512'h0},     D_ABC256};
    vecs[1] = '{1, 1'b0, 2, 1'b1, {TWO_B1, TWO_B2},  D_TWO};
    vecs[2] = '{2, 1'b0, 1, 1'b0, {ABC, 512'h0},     D_ABC256};
    vecs[3] = '{2, 1'b1, 1, 1'b0, {ABC, 512'h0},     D_ABC224};
    vecs[4] = '{1, 1'b1, 1, 1'b1, {ABC, 512'h0},     D_ABC224};

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].nblk; b++) begin
        if (b == vecs[v].nblk - 1) exp_q.push_back(vecs[v].exp);
        send_words(vecs[v].inst, vecs[v].msg[1023 - 512*b -: 512], b == 0,
                   b == vecs[v].nblk - 1, vecs[v].mode, vecs[v].gaps, 16);
        finish_block(vecs[v].inst, b == vecs[v].nblk - 1, $sformatf("vec%0d_blk%0d", v, b));
      end
    end

    // Abort about 20 rounds into HASH on the R=1 instance.
    send_words(0, ABC, 1'b1, 1'b1, 1'b0, 1'b0, 16);
    repeat (20) @(negedge clk);
    abort_i[0] = 1'b1;
    @(negedge clk);
    abort_i[0] = 1'b0;
    check("abort_ready", 256'(word_ready_o[0]), 256'(1));
    check("abort_busy", 256'(busy_o[0]), 256'(0));
    check("abort_dvalid", 256'(digest_valid_o[0]), 256'(0));
    check("abort_digest", digest_o[0], 256'(0));
    run_abc(0, 1'b0, D_ABC256, "after_abort");

    // Abort wins over a word offered in the same cycle.
    word_i[0] = 32'hdeadbeef;
    first_i[0] = 1'b1;
    mode_i[0] = 1'b1;
    word_valid_i[0] = 1'b1;
    abort_i[0] = 1'b1;
    @(negedge clk);
    word_valid_i[0] = 1'b0;
    abort_i[0] = 1'b0;
    run_abc(0, 1'b0, D_ABC256, "abort_drop");

    // Reset after word 7 of a block on the R=4 instance.
    send_words(1, ABC, 1'b1, 1'b1, 1'b0, 1'b0, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    rst_n = 1'b1;
    run_abc(1, 1'b0, D_ABC256, "after_reset");

    // Digest holds while idle, then drops on the next first word.
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (digest_o[1] !== D_ABC256 || digest_valid_o[1] !== 1'b1) stable = 1'b0;
    end
    check("digest_hold", 256'(stable), 256'(1));
    word_i[1] = 32'h61626380;
    first_i[1] = 1'b1;
    mode_i[1] = 1'b0;
    word_valid_i[1] = 1'b1;
    @(negedge clk);
    word_valid_i[1] = 1'b0;
    check("dvalid_drop_on_first", 256'(digest_valid_o[1]), 256'(0));
    check("busy_after_word0", 256'(busy_o[1]), 256'(0));
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    abort_i[1] = 1'b1;
    @(negedge clk);
    abort_i[1] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

SHA-256/224 compression core with a 32-bit word-streaming input and a configurable number of rounds per clock. It replaces the 512-bit parallel-load `sha256` block in designs that feed message words from a FIFO or bus. Message framing uses first/last flags, so multi-block messages need no separate init/next strobes. Abort is supported without a reset.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: SHA rounds per clock. Legal values are 1, 2, 4, 8. The round datapath is unrolled this many times.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode_i`  in  1  0 = SHA-256, 1 = SHA-224. Sampled only with word 0 when `first_i`=1.
- `word_i`  in  32  message word. Word 0 of a block is block bits [511:480] (big-endian).
- `word_valid_i`  in  1  `word_i` is valid.
- `word_ready_o`  out  1  core accepts a word. A handshake occurs when valid and ready are both high at a rising edge.
- `first_i`  in  1  sampled with word 0 only: this block starts a new message.
- `last_i`  in  1  sampled with word 15 only: this block ends the message.
- `abort_i`  in  1  discard the current message.
- `busy_o`  out  1  high in HASH or UPDATE.
- `digest_o`  out  256  H0..H7, H0 in the MSBs. In SHA-224 mode, bits [31:0] read 0.
- `digest_valid_o`  out  1  `digest_o` holds a final digest.

## Operation
- States:
  - LOAD: accept words 0..15; `word_ready_o`=1.
  - HASH: 64/`ROUNDS_PER_CYCLE` cycles.
  - UPDATE: 1 cycle.
- Reset state:
  - state = LOAD, word count = 0, round counter = 0.
  - H = SHA-256 IV, mode = SHA-256.
  - `word_ready_o`=1, `busy_o`=0, `digest_valid_o`=0, `digest_o`=0.
- LOAD:
  - Each handshake shifts the word into W[0..15] and increments the word count.
  - Word 0 with `first_i`=1: H loads the IV for `mode_i`, the mode latches, and `digest_valid_o` clears.
  - Word 0 with `first_i`=0: the message continues from the current H.
  - Word 15: latch `last_i`, load a..h from H, clear the round counter, go to HASH.
- HASH:
  - Each cycle runs `ROUNDS_PER_CYCLE` chained FIPS 180-4 rounds.
  - The schedule is a 16-word sliding window, extended by `ROUNDS_PER_CYCLE` words per cycle.
  - K constants are indexed by round counter + i.
  - The round counter advances by `ROUNDS_PER_CYCLE` each cycle. When it reaches 64 − `ROUNDS_PER_CYCLE`, go to UPDATE.
- UPDATE:
  - Hi = Hi + working variable, modulo 2^32 per word.
  - If the latched last flag is set: `digest_o` ← new H (SHA-224 forces [31:0]=0) and `digest_valid_o` ← 1.
  - Go to LOAD with word count 0.
- `digest_o`/`digest_valid_o` hold until the next word 0 with `first_i`=1, abort, or reset. Intermediate (non-last) blocks never change `digest_o`.
- IVs:
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- Abort:
  - Effective in any state. Next edge: state LOAD, word count 0, H = SHA-256 IV, `digest_valid_o`=0, `digest_o`=0.
  - Abort has priority over a simultaneous word handshake; that word is dropped.

## Timing
- Word 15 handshake at edge t0:
  - HASH occupies edges t0+1 .. t0+64/R (R = `ROUNDS_PER_CYCLE`).
  - UPDATE occurs at edge t0+64/R+1.
  - `digest_valid_o` (if last) and `word_ready_o` are high after edge t0+64/R+1.
  - For R=1 this is 65 cycles after word 15; for R=4, 17 cycles.
- `word_ready_o` is low for exactly 64/R+1 cycles per block. Full-rate streaming then gives 16 + 64/R + 1 cycles per block.
- `word_valid_i` may drop between words. Gaps only stall LOAD; no timeout applies.
- `first_i`/`last_i` are don't-care on all words except 0 and 15 respectively.
- `rst_n` low mid-HASH: the next edge gives the reset state; no partial digest is output.
- `word_ready_o` and `busy_o` are registered or decoded from state register only, with no combinational path from inputs.

## Test plan
- **"abc", SHA-256, R=1, back-to-back valid.** Stimulus: words 61626380, 0 ×14, 00000018, `first_i`=`last_i`=1. Required response: `digest_o` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `digest_valid_o` high exactly 65 cycles after word 15.
- **Two-block message, R=4, random valid gaps.** Stimulus: block 1 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" + 80000000 + 00000000, `first_i`=1, `last_i`=0. Block 2 = 0 ×14, 00000000, 000001c0, `first_i`=0, `last_i`=1. Required response:
  - `digest_valid_o` stays 0 after block 1.
  - Final `digest_o` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - Each ready-low window is 17 cycles.
- **"abc", SHA-224 (`mode_i`=1), R=8, issued directly after the SHA-256 test without reset.** Required response: `digest_o` = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000.
- **Abort mid-HASH.** Stimulus: start "abc", assert `abort_i` for 1 cycle at round 20. Required response:
  - Next cycle `word_ready_o`=1, `busy_o`=0, `digest_valid_o`=0.
  - Re-sending "abc" yields the correct SHA-256 digest.
- **Reset mid-LOAD.** Stimulus: assert `rst_n`=0 after word 7. Required response: all outputs at reset values next edge; a full "abc" afterwards gives the correct digest.
- **Digest hold.** After "abc" completes, hold `word_valid_i`=0 for 100 cycles, then send a word 0 with `first_i`=1. Required response:
  - `digest_o`/`digest_valid_o` stable throughout the idle period.
  - `digest_valid_o` drops on the edge that accepts word 0.
